// File: rtl/cpc_bankreg_wr.sv
// rtl/cpc_bankreg_wr.sv - synchronised, glitch-qualified write path for the CPC 0x7Fxx bank register
// Optional ADR_FULLDECODE_EN: decode the full adr[15:8]==0x7F instead of the CPC partial decode (adr[15]==0).
module cpc_bankreg_wr #(
  parameter int QUAL_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       busreset_b,
  input  logic       iorq_b,
  input  logic       wr_b,
  input  logic [7:0] adr,
  input  logic [7:0] data,
  output logic [5:0] bank_q,
  output logic       bank_we,
  output logic       wr_busy
);

  typedef enum logic [1:0] {IDLE, QUAL, STROBE, HOLD} state_e;

  localparam int              SW        = 19;
  localparam logic [SW-1:0]   SYNC_RST  = {3'b111, 16'h0000};
  localparam logic [3:0]      QUAL_LAST = 4'(QUAL_CYCLES);

  logic [SW-1:0] sync_s1_q, sync_s1_d;
  logic [SW-1:0] sync_s2_q, sync_s2_d;
  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [5:0]    bank_d;
  logic          bank_we_q, bank_we_d;

  logic       busreset_b_s2, iorq_b_s2, wr_b_s2;
  logic [7:0] adr_s2, data_s2;
  logic       port_hit, match, enter_strobe;

  assign busreset_b_s2 = sync_s2_q[18];
  assign iorq_b_s2     = sync_s2_q[17];
  assign wr_b_s2       = sync_s2_q[16];
  assign adr_s2        = sync_s2_q[15:8];
  assign data_s2       = sync_s2_q[7:0];

`ifdef ADR_FULLDECODE_EN
  assign port_hit = (adr_s2 == 8'h7F);
`else
  // The CPC only decodes A15 for the gate array port; the low address bits are don't-care.
  logic unused_adr;
  assign unused_adr = ^adr_s2[6:0];
  assign port_hit   = ~adr_s2[7];
`endif

  assign match = ~iorq_b_s2 & ~wr_b_s2 & port_hit & data_s2[7] & data_s2[6];

  always_comb begin
    sync_s1_d    = {busreset_b, iorq_b, wr_b, adr, data};
    sync_s2_d    = sync_s1_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    bank_d       = bank_q;
    bank_we_d    = 1'b0;
    enter_strobe = 1'b0;

    case (state_q)
      IDLE: begin
        if (match) begin
          if (QUAL_CYCLES == 1) begin
            enter_strobe = 1'b1;
          end else begin
            state_d = QUAL;
            cnt_d   = 4'd1;
          end
        end
      end
      QUAL: begin
        if (!match) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q + 4'd1 == QUAL_LAST) begin
          enter_strobe = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      STROBE: state_d = HOLD;
      HOLD: begin
        if (iorq_b_s2 | wr_b_s2) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Capture happens on the edge that enters STROBE, so bank_q and bank_we change together.
    if (enter_strobe) begin
      state_d   = STROBE;
      cnt_d     = 4'd0;
      bank_d    = data_s2[5:0];
      bank_we_d = 1'b1;
    end

    if (!busreset_b_s2) begin
      state_d   = IDLE;
      cnt_d     = 4'd0;
      bank_d    = 6'd0;
      bank_we_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_s1_q <= SYNC_RST;
      sync_s2_q <= SYNC_RST;
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      bank_q    <= 6'd0;
      bank_we_q <= 1'b0;
    end else begin
      sync_s1_q <= sync_s1_d;
      sync_s2_q <= sync_s2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bank_q    <= bank_d;
      bank_we_q <= bank_we_d;
    end
  end

  assign bank_we = bank_we_q;
  assign wr_busy = (state_q != IDLE);

endmodule

// File: tb/tb_cpc_bankreg_wr.sv
// tb/tb_cpc_bankreg_wr.sv - vector table, corner sequences and random traffic against a run-length reference model
`timescale 1ns/1ps
module tb_cpc_bankreg_wr;

  localparam int QC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       busreset_b = 1'b1;
  logic       iorq_b = 1'b1;
  logic       wr_b = 1'b1;
  logic [7:0] adr = 8'h00;
  logic [7:0] data = 8'h00;
  logic [5:0] bank_q;
  logic       bank_we;
  logic       wr_busy;

  cpc_bankreg_wr #(.QUAL_CYCLES(QC)) dut (
    .clk(clk), .reset(reset), .busreset_b(busreset_b), .iorq_b(iorq_b), .wr_b(wr_b),
    .adr(adr), .data(data), .bank_q(bank_q), .bank_we(bank_we), .wr_busy(wr_busy)
  );

  always #125 clk = ~clk;

  typedef struct packed {
    logic       busreset_b;
    logic       iorq_b;
    logic       wr_b;
    logic [7:0] adr;
    logic [7:0] data;
  } raw_t;

  typedef struct {
    logic [7:0] adr;
    logic [7:0] data;
    int         low;
    logic [5:0] exp_bank;
    int         exp_pulses;
  } vec_t;

  localparam raw_t RAW_IDLE = {3'b111, 16'h0000};

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  raw_t h1 = RAW_IDLE, h2 = RAW_IDLE;
  logic [5:0] m_bank = 6'd0;
  logic       m_we = 1'b0;
  int         m_run = 0;
  bit         m_strobe = 1'b0;
  bit         m_locked = 1'b0;

  function automatic bit raw_match(raw_t r);
    bit hit;
`ifdef ADR_FULLDECODE_EN
    hit = (r.adr == 8'h7F);
`else
    hit = (r.adr < 8'h80);
`endif
    return !r.iorq_b && !r.wr_b && hit && (r.data[7:6] == 2'b11);
  endfunction

  // A write is accepted once QC consecutive synchronised samples match; afterwards nothing
  // more is accepted until iorq_b or wr_b is seen high after the one strobe cycle.
  task automatic model_edge(raw_t now, logic rst);
    m_we = 1'b0;
    if (rst) begin
      m_bank = 6'd0; m_run = 0; m_strobe = 0; m_locked = 0;
      h1 = RAW_IDLE; h2 = RAW_IDLE;
      return;
    end
    if (!h2.busreset_b) begin
      m_bank = 6'd0; m_run = 0; m_strobe = 0; m_locked = 0;
    end else if (m_strobe) begin
      m_strobe = 0; m_locked = 1;
    end else if (m_locked) begin
      if (h2.iorq_b || h2.wr_b) m_locked = 0;
    end else begin
      m_run = raw_match(h2) ? m_run + 1 : 0;
      if (m_run == QC) begin
        m_bank = h2.data[5:0]; m_we = 1'b1; m_strobe = 1; m_run = 0;
      end
    end
    h2 = h1;
    h1 = now;
  endtask

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    raw_t now;
    now = {busreset_b, iorq_b, wr_b, adr, data};
    model_edge(now, reset);
    @(posedge clk);
    #1;
    check("model_bank_q", {2'b00, bank_q}, {2'b00, m_bank});
    check("model_bank_we", {7'd0, bank_we}, {7'd0, m_we});
    check("model_wr_busy", {7'd0, wr_busy}, {7'd0, (m_run > 0) || m_strobe || m_locked});
    if (bank_we === 1'b1) pulses++;
  endtask

  task automatic bus_write(logic [7:0] a, logic [7:0] d, int low);
    adr = a; data = d; iorq_b = 1'b0; wr_b = 1'b0;
    repeat (low) step();
    iorq_b = 1'b1; wr_b = 1'b1;
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'h7F, 8'hC2, 3, 6'h02, 1};
    vecs[1] = '{8'h7F, 8'hFF, 1, 6'h02, 0};
    vecs[2] = '{8'h7F, 8'h8A, 4, 6'h02, 0};
    vecs[3] = '{8'hBF, 8'hC5, 4, 6'h02, 0};
`ifdef ADR_FULLDECODE_EN
    vecs[4] = '{8'h7E, 8'hD3, 4, 6'h02, 0};
`else
    vecs[4] = '{8'h7E, 8'hD3, 4, 6'h13, 1};
`endif
    vecs[5] = '{8'h7F, 8'hCF, 10, 6'h0F, 1};
    vecs[6] = '{8'h7F, 8'hC0, 3, 6'h00, 1};

    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    check("reset_bank_q", {2'b00, bank_q}, 8'h00);
    check("reset_bank_we", {7'd0, bank_we}, 8'h00);
    check("reset_wr_busy", {7'd0, wr_busy}, 8'h00);
    step();

    foreach (vecs[i]) begin
      pulses = 0;
      bus_write(vecs[i].adr, vecs[i].data, vecs[i].low);
      repeat (5) step();
      check($sformatf("vec%0d_bank_q", i), {2'b00, bank_q}, {2'b00, vecs[i].exp_bank});
      check($sformatf("vec%0d_pulses", i), 8'(pulses), 8'(vecs[i].exp_pulses));
      check($sformatf("vec%0d_busy", i), {7'd0, wr_busy}, 8'h00);
    end

    // Latency: bank_we rises on E0+3 and lasts exactly one edge.
    adr = 8'h7F; data = 8'hD5; iorq_b = 1'b0; wr_b = 1'b0;
    step();
    step();
    step();
    check("lat_we_before", {7'd0, bank_we}, 8'h00);
    iorq_b = 1'b1; wr_b = 1'b1;
    step();
    check("lat_we_e3", {7'd0, bank_we}, 8'h01);
    check("lat_bank_e3", {2'b00, bank_q}, 8'h15);
    step();
    check("lat_we_e4", {7'd0, bank_we}, 8'h00);
    repeat (3) step();
    check("lat_busy_after", {7'd0, wr_busy}, 8'h00);

    // Back-to-back with no release: second decode is absorbed.
    pulses = 0;
    adr = 8'h7F; data = 8'hC1; iorq_b = 1'b0; wr_b = 1'b0;
    repeat (4) step();
    data = 8'hC3;
    repeat (4) step();
    iorq_b = 1'b1; wr_b = 1'b1;
    repeat (4) step();
    check("b2b_nogap_pulses", 8'(pulses), 8'd1);
    check("b2b_nogap_bank", {2'b00, bank_q}, 8'h01);

    // One released cycle between writes is enough for a second update.
    pulses = 0;
    bus_write(8'h7F, 8'hC6, 4);
    step();
    bus_write(8'h7F, 8'hC7, 4);
    repeat (4) step();
    check("b2b_gap_pulses", 8'(pulses), 8'd2);
    check("b2b_gap_bank", {2'b00, bank_q}, 8'h07);

    // Bus reset arriving at E0+1 clears bank_q and wins over the STROBE entry edge.
    bus_write(8'h7F, 8'hEA, 3);
    repeat (4) step();
    check("busrst_preload", {2'b00, bank_q}, 8'h2A);
    pulses = 0;
    adr = 8'h7F; data = 8'hC5; iorq_b = 1'b0; wr_b = 1'b0;
    step();
    busreset_b = 1'b0;
    step();
    step();
    iorq_b = 1'b1; wr_b = 1'b1;
    busreset_b = 1'b1;
    repeat (5) step();
    check("busrst_bank", {2'b00, bank_q}, 8'h00);
    check("busrst_pulses", 8'(pulses), 8'd0);
    check("busrst_idle", {7'd0, wr_busy}, 8'h00);

    repeat (400) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end else if (r == 1) begin
        busreset_b = 1'b0;
        repeat ($urandom_range(1, 3)) step();
        busreset_b = 1'b1;
      end else begin
        case ($urandom_range(0, 3))
          0: adr = 8'h7F;
          1: adr = 8'h7E;
          2: adr = 8'hBF;
          default: adr = 8'($urandom);
        endcase
        data = ($urandom_range(0, 3) != 0) ? {2'b11, 6'($urandom)} : 8'($urandom);
        iorq_b = 1'b0;
        wr_b = ($urandom_range(0, 7) == 0);
        repeat ($urandom_range(1, 6)) step();
        iorq_b = 1'b1; wr_b = 1'b1;
        repeat ($urandom_range(0, 3)) step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
